// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared types and constants for the USB packet receiver.
// FSM state encoding, PID classes, line states and stuffing limits.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_DATA,
        S_EOP,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [2:0] PKT_NONE  = 3'd0;
    localparam logic [2:0] PKT_OUT   = 3'd1;
    localparam logic [2:0] PKT_IN    = 3'd2;
    localparam logic [2:0] PKT_DATA0 = 3'd3;
    localparam logic [2:0] PKT_DATA1 = 3'd4;
    localparam logic [2:0] PKT_ACK   = 3'd5;
    localparam logic [2:0] PKT_NAK   = 3'd6;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    // {D+, D-}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int MAX_STUFF_ONES = 6;

    // Returns PKT_NONE for a malformed or unsupported PID.
    function automatic logic [2:0] pid_class(input logic [7:0] pid);
        logic [2:0] cls;
        cls = PKT_NONE;
        if (pid[7:4] == ~pid[3:0]) begin
            case (pid[3:0])
                PID_OUT:   cls = PKT_OUT;
                PID_IN:    cls = PKT_IN;
                PID_DATA0: cls = PKT_DATA0;
                PID_DATA1: cls = PKT_DATA1;
                PID_ACK:   cls = PKT_ACK;
                PID_NAK:   cls = PKT_NAK;
                default:   cls = PKT_NONE;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/usb_rx_bit_recovery.sv
// usb_rx_bit_recovery: line sync, bit timing, NRZI decode, unstuffing.
// In: clk, n_rst, dplus_in, dminus_in, unstuff_en_i.
// Out: bit_valid_o, bit_o, se0_o, j_o, stuff_err_o (one-cycle qualifiers).
module usb_rx_bit_recovery
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic dplus_in,
    input  logic dminus_in,
    input  logic unstuff_en_i,
    output logic bit_valid_o,
    output logic bit_o,
    output logic se0_o,
    output logic j_o,
    output logic stuff_err_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [1:0]    dp_sync_q;
    logic [1:0]    dm_sync_q;
    logic          dp_last_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q, prev_d;
    logic [2:0]    ones_q, ones_d;

    logic [1:0] line;
    logic       edge_det;
    logic       sample_en;
    logic       sample_bit;
    logic       nrzi_bit;
    logic       stuff_slot;

    // Synchronizers come out of reset already showing idle J.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_sync_q <= 2'b11;
            dm_sync_q <= 2'b00;
            dp_last_q <= 1'b1;
            cnt_q     <= '0;
            prev_q    <= 1'b1;
            ones_q    <= '0;
        end else begin
            dp_sync_q <= {dp_sync_q[0], dplus_in};
            dm_sync_q <= {dm_sync_q[0], dminus_in};
            dp_last_q <= dp_sync_q[1];
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
            ones_q    <= ones_d;
        end
    end

    assign line     = {dp_sync_q[1], dm_sync_q[1]};
    assign edge_det = dp_sync_q[1] ^ dp_last_q;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (edge_det || cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_d = '0;
        end
    end

    // An edge landing on the sample count would sample the new level twice.
    assign sample_en  = (cnt_q == CW'(SAMPLE_POINT)) && !edge_det;
    assign se0_o      = sample_en && (line == LINE_SE0);
    assign j_o        = sample_en && (line == LINE_J);
    assign sample_bit = sample_en && (line != LINE_SE0);
    assign nrzi_bit   = (dp_sync_q[1] == prev_q);
    assign stuff_slot = unstuff_en_i && (ones_q == 3'(MAX_STUFF_ONES));

    assign bit_o       = nrzi_bit;
    assign bit_valid_o = sample_bit && !stuff_slot;
    assign stuff_err_o = sample_bit && stuff_slot && nrzi_bit;

    always_comb begin
        prev_d = sample_bit ? dp_sync_q[1] : prev_q;
        ones_d = ones_q;
        if (!unstuff_en_i || se0_o) begin
            ones_d = '0;
        end else if (sample_bit) begin
            if (stuff_slot || !nrzi_bit) begin
                ones_d = '0;
            end else begin
                ones_d = ones_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/usb_rx.sv
// usb_rx: USB full-speed packet receiver (SYNC/PID check, byte delivery).
// In: clk, n_rst, dplus_in, dminus_in. Out: rx_packet_data, store_rx_packet_data,
// rx_packet, rx_data_ready, rx_transfer_active, rx_error.
module usb_rx
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3,
    parameter int MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       dplus_in,
    input  logic       dminus_in,
    output logic [7:0] rx_packet_data,
    output logic       store_rx_packet_data,
    output logic [2:0] rx_packet,
    output logic       rx_data_ready,
    output logic       rx_transfer_active,
    output logic       rx_error
);

    localparam int BW = $clog2(MAX_BYTES + 1);

    state_e state_q, state_d;

    logic bit_valid, rx_bit, se0, line_j, stuff_err, unstuff_en;

    logic [7:0]    shift_q, data_q, shift_nxt;
    logic [2:0]    bitcnt_q, pkt_q, jcnt_q, pid_cls;
    logic [BW-1:0] bytecnt_q;
    logic          strobe_q, err_q, hs_q, eop_q;
    logic          byte_done, sop;

    usb_rx_bit_recovery #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .SAMPLE_POINT(SAMPLE_POINT)
    ) u_bit (
        .clk         (clk),
        .n_rst       (n_rst),
        .dplus_in    (dplus_in),
        .dminus_in   (dminus_in),
        .unstuff_en_i(unstuff_en),
        .bit_valid_o (bit_valid),
        .bit_o       (rx_bit),
        .se0_o       (se0),
        .j_o         (line_j),
        .stuff_err_o (stuff_err)
    );

    assign shift_nxt = {rx_bit, shift_q[7:1]};
    assign byte_done = bit_valid && (bitcnt_q == 3'd7);
    assign pid_cls   = pid_class(shift_nxt);
    assign sop       = (state_q == S_IDLE) && (state_d == S_SYNC);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                // The J->K edge is also the first SYNC bit.
                if (bit_valid && !rx_bit) state_d = S_SYNC;
            end
            S_SYNC: begin
                if (se0 || stuff_err) state_d = S_ERROR;
                else if (byte_done)
                    state_d = (shift_nxt == SYNC_BYTE) ? S_PID : S_ERROR;
            end
            S_PID: begin
                if (se0 || stuff_err) state_d = S_ERROR;
                else if (byte_done)
                    state_d = (pid_cls != PKT_NONE) ? S_DATA : S_ERROR;
            end
            S_DATA: begin
                if (stuff_err) state_d = S_ERROR;
                else if (se0)
                    state_d = (bitcnt_q == 3'd0) ? S_EOP : S_ERROR;
                else if (bit_valid && hs_q) state_d = S_ERROR;
                else if (byte_done && bytecnt_q == BW'(MAX_BYTES))
                    state_d = S_ERROR;
            end
            S_EOP: begin
                if (se0) begin
                    if (eop_q) state_d = S_ERROR;
                end else if (line_j) begin
                    state_d = eop_q ? S_DONE : S_ERROR;
                end else if (bit_valid || stuff_err) begin
                    state_d = S_ERROR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: begin
                if (line_j && jcnt_q == 3'd7) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_transfer_active = 1'b0;
        rx_data_ready      = 1'b0;
        unstuff_en         = 1'b0;
        unique case (state_q)
            S_SYNC, S_PID, S_DATA, S_EOP: begin
                rx_transfer_active = 1'b1;
                unstuff_en         = 1'b1;
            end
            S_DONE:  rx_data_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_q   <= '0;
            data_q    <= '0;
            bitcnt_q  <= '0;
            bytecnt_q <= '0;
            pkt_q     <= PKT_NONE;
            jcnt_q    <= '0;
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
            hs_q      <= 1'b0;
            eop_q     <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (sop) begin
                shift_q   <= shift_nxt;
                bitcnt_q  <= 3'd1;
                bytecnt_q <= '0;
                pkt_q     <= PKT_NONE;
                err_q     <= 1'b0;
                hs_q      <= 1'b0;
            end else if (bit_valid && (state_q == S_SYNC ||
                         state_q == S_PID || state_q == S_DATA)) begin
                shift_q  <= shift_nxt;
                bitcnt_q <= bitcnt_q + 3'd1;
            end
            if (state_q == S_PID && state_d == S_DATA) begin
                pkt_q <= pid_cls;
                hs_q  <= (pid_cls == PKT_ACK) || (pid_cls == PKT_NAK);
            end
            if (state_q == S_DATA && state_d == S_DATA && byte_done) begin
                data_q    <= shift_nxt;
                strobe_q  <= 1'b1;
                bytecnt_q <= bytecnt_q + BW'(1);
            end
            if (state_q != S_EOP) eop_q <= 1'b0;
            else if (se0)         eop_q <= 1'b1;
            if (state_q != S_ERROR)     jcnt_q <= '0;
            else if (line_j)            jcnt_q <= jcnt_q + 3'd1;
            else if (se0 || bit_valid)  jcnt_q <= '0;
            if (state_d == S_ERROR) err_q <= 1'b1;
        end
    end

    assign rx_packet_data       = data_q;
    assign store_rx_packet_data = strobe_q;
    assign rx_packet            = pkt_q;
    assign rx_error             = err_q;

endmodule

// File: tb/tb_usb_rx.sv
// tb_usb_rx: directed bench for usb_rx; builds NRZI/stuffed line traffic
// and checks packet class, delivered bytes, EOP pulse and error handling.
module tb_usb_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       dplus_in = 1'b1;
    logic       dminus_in = 1'b0;
    logic [7:0] rx_packet_data;
    logic       store_rx_packet_data;
    logic [2:0] rx_packet;
    logic       rx_data_ready;
    logic       rx_transfer_active;
    logic       rx_error;

    usb_rx #(
        .CLKS_PER_BIT(CPB),
        .SAMPLE_POINT(3),
        .MAX_BYTES   (64)
    ) dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .dplus_in            (dplus_in),
        .dminus_in           (dminus_in),
        .rx_packet_data      (rx_packet_data),
        .store_rx_packet_data(store_rx_packet_data),
        .rx_packet           (rx_packet),
        .rx_data_ready       (rx_data_ready),
        .rx_transfer_active  (rx_transfer_active),
        .rx_error            (rx_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_str = 0;
    int n_rdy = 0;
    logic [7:0] data_log [0:63];

    logic lvl = 1'b1;
    int   ones = 0;
    int   bs, br;

    always @(negedge clk) begin
        if (store_rx_packet_data && n_str < 64) begin
            data_log[n_str] = rx_packet_data;
            n_str++;
        end
        if (rx_data_ready) n_rdy++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic dp, input logic dm, input int n);
        dplus_in  = dp;
        dminus_in = dm;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic line_bit(input logic b, input logic stuff);
        if (!b) lvl = ~lvl;
        drive(lvl, ~lvl, 1);
        if (stuff) begin
            ones = b ? ones + 1 : 0;
            if (ones == 6) begin
                lvl = ~lvl;
                drive(lvl, ~lvl, 1);
                ones = 0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input logic stuff);
        for (int i = 0; i < 8; i++) line_bit(v[i], stuff);
    endtask

    task automatic start_pkt(input logic [7:0] pid);
        ones = 0;
        send_byte(8'h80, 1'b1);
        send_byte(pid, 1'b1);
    endtask

    task automatic eop();
        drive(1'b0, 1'b0, 2);
        lvl = 1'b1;
        drive(1'b1, 1'b0, 1);
    endtask

    task automatic idle(input int n);
        lvl = 1'b1;
        drive(1'b1, 1'b0, n);
    endtask

    task automatic snap();
        bs = n_str;
        br = n_rdy;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data", rx_packet_data, 8'h00);
        chk("rst_strobe", store_rx_packet_data, 1'b0);
        chk("rst_pkt", rx_packet, 3'd0);
        chk("rst_ready", rx_data_ready, 1'b0);
        chk("rst_active", rx_transfer_active, 1'b0);
        chk("rst_err", rx_error, 1'b0);
        n_rst = 1'b1;
        idle(4);

        // ACK handshake
        snap();
        start_pkt(8'hD2);
        chk("ack_active", rx_transfer_active, 1'b1);
        eop();
        idle(4);
        chk("ack_pkt", rx_packet, 3'd5);
        chk("ack_strobes", n_str - bs, 0);
        chk("ack_ready", n_rdy - br, 1);
        chk("ack_err", rx_error, 1'b0);
        chk("ack_idle", rx_transfer_active, 1'b0);

        // DATA0 with stuffed payload and CRC bytes
        snap();
        start_pkt(8'hC3);
        send_byte(8'h01, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3F, 1'b1);
        send_byte(8'hBF, 1'b1);
        eop();
        idle(4);
        chk("d0_pkt", rx_packet, 3'd3);
        chk("d0_strobes", n_str - bs, 4);
        chk("d0_b0", data_log[bs], 8'h01);
        chk("d0_b1", data_log[bs + 1], 8'hFF);
        chk("d0_b2", data_log[bs + 2], 8'h3F);
        chk("d0_b3", data_log[bs + 3], 8'hBF);
        chk("d0_ready", n_rdy - br, 1);
        chk("d0_err", rx_error, 1'b0);

        // Malformed PID
        snap();
        start_pkt(8'hC2);
        chk("pid_err", rx_error, 1'b1);
        chk("pid_active", rx_transfer_active, 1'b0);
        eop();
        idle(10);
        chk("pid_strobes", n_str - bs, 0);
        chk("pid_ready", n_rdy - br, 0);
        snap();
        start_pkt(8'hD2);
        eop();
        idle(4);
        chk("pid_clr_err", rx_error, 1'b0);
        chk("pid_clr_pkt", rx_packet, 3'd5);
        chk("pid_clr_ready", n_rdy - br, 1);

        // Missing stuff bit, then slow recovery
        snap();
        start_pkt(8'h4B);
        send_byte(8'hFF, 1'b0);
        chk("stf_err", rx_error, 1'b1);
        chk("stf_active", rx_transfer_active, 1'b0);
        lvl = 1'b0;
        drive(1'b0, 1'b1, 1);
        idle(3);
        start_pkt(8'hD2);
        eop();
        idle(10);
        chk("stf_hold_pkt", rx_packet, 3'd4);
        chk("stf_hold_err", rx_error, 1'b1);
        chk("stf_hold_ready", n_rdy - br, 0);
        chk("stf_strobes", n_str - bs, 0);
        snap();
        start_pkt(8'hD2);
        eop();
        idle(4);
        chk("stf_rec_pkt", rx_packet, 3'd5);
        chk("stf_rec_err", rx_error, 1'b0);
        chk("stf_rec_ready", n_rdy - br, 1);

        // SE0 in the middle of a byte
        snap();
        start_pkt(8'h4B);
        send_byte(8'hA5, 1'b1);
        line_bit(1'b1, 1'b1);
        line_bit(1'b1, 1'b1);
        line_bit(1'b0, 1'b1);
        line_bit(1'b0, 1'b1);
        eop();
        idle(10);
        chk("se0_strobes", n_str - bs, 1);
        chk("se0_byte", data_log[bs], 8'hA5);
        chk("se0_err", rx_error, 1'b1);
        chk("se0_ready", n_rdy - br, 0);

        // Reset mid-DATA
        snap();
        start_pkt(8'hC3);
        send_byte(8'h55, 1'b1);
        line_bit(1'b1, 1'b1);
        chk("mr_pkt", rx_packet, 3'd3);
        chk("mr_active", rx_transfer_active, 1'b1);
        chk("mr_byte", data_log[bs], 8'h55);
        n_rst = 1'b0;
        dplus_in = 1'b1;
        dminus_in = 1'b0;
        #1;
        chk("mr_rst_data", rx_packet_data, 8'h00);
        chk("mr_rst_strobe", store_rx_packet_data, 1'b0);
        chk("mr_rst_pkt", rx_packet, 3'd0);
        chk("mr_rst_ready", rx_data_ready, 1'b0);
        chk("mr_rst_active", rx_transfer_active, 1'b0);
        chk("mr_rst_err", rx_error, 1'b0);
        repeat (4) @(negedge clk);
        n_rst = 1'b1;
        idle(4);
        snap();
        start_pkt(8'hD2);
        eop();
        idle(4);
        chk("mr_ack_pkt", rx_packet, 3'd5);
        chk("mr_ack_ready", n_rdy - br, 1);
        chk("mr_ack_err", rx_error, 1'b0);
        chk("mr_ack_strobes", n_str - bs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
